fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Single owner of the on-chip frame-buffer write port. Shares it between N_REQ burst
//  writers (blue trail, red trail sequencers) and an internal clear engine that wipes
//  the play area when a new round starts. Sits between the trail writers and the OCM.
//  All OCM write outputs are registered.
// PARAMETERS
//  AW          20      frame-buffer word address width
//  DW          16      frame-buffer data width
//  N_REQ       2       number of burst requesters (index 0 = blue, 1 = red)
//  CLEAR_BASE  0       first word address wiped by the clear engine
//  CLEAR_WORDS 307200  number of words wiped; CLEAR_BASE+CLEAR_WORDS <= 2**AW (elab check)
//  CLEAR_VALUE 16'h0   data written during clear
//  MAX_BURST   64      words per grant before forced release
// PORTS
//  Clk          in   1           system clock, 50 MHz
//  Reset        in   1           synchronous, active-high
//  clear_start  in   1           1-cycle pulse: request play-area wipe
//  clear_busy   out  1           high from clear accept until last clear word written
//  req          in   N_REQ       requester wants port / has a valid word this cycle
//  last         in   N_REQ       qualifies req: this word ends the burst
//  wr_addr      in   N_REQ*AW    per-requester word address (packed, index i at [i*AW+:AW])
//  wr_data      in   N_REQ*DW    per-requester word data (packed)
//  gnt          out  N_REQ       one-hot (or zero) registered grant
//  ack          out  N_REQ       gnt & req: word accepted this cycle (combinational)
//  fb_we        out  1           OCM write enable
//  fb_addr      out  AW          OCM write address
//  fb_data      out  DW          OCM write data
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, fb_we=0, fb_addr=0, fb_data=0, clear_busy=0,
//   clear_pend=0, rr_ptr=0, burst_cnt=0.
//  FSM states: IDLE, CLEAR, BURST.
//  IDLE: clear_pend|clear_start -> CLEAR (priority over requesters); else any req ->
//   BURST with gnt set next cycle to first req at or after rr_ptr (round robin, wraps
//   N_REQ-1 -> 0). No req -> stay. gnt=0 in IDLE and CLEAR.
//  BURST: each cycle with ack[g]=1, fb_we=1, fb_addr=wr_addr[g], fb_data=wr_data[g] on
//   next cycle (1-cycle latency); burst_cnt++. req[g]=0 -> stall, fb_we=0, keep grant.
//   Exit to IDLE after the accepted word with last[g]=1 or burst_cnt reaching MAX_BURST
//   (that word is still written); gnt drops next cycle; rr_ptr=g+1 mod N_REQ.
//  Requester drops gnt-less requests freely; words presented without gnt are never written.
//  CLEAR: clear_busy=1; one word per cycle, fb_addr CLEAR_BASE..CLEAR_BASE+CLEAR_WORDS-1,
//   fb_data=CLEAR_VALUE, fb_we=1; after last word -> IDLE, clear_busy=0 same cycle fb_we
//   of last word is visible.
//  clear_start while BURST: latched in clear_pend, clear_busy=1 immediately; clear
//   begins after burst exits. clear_start while CLEAR: ignored (no restart, no extend).
//  clear_start and req same cycle in IDLE: clear wins; req waits.
//  Reset mid-burst or mid-clear: abort at once, no further fb_we, pending clear discarded.
//  Clear counter width = $clog2(CLEAR_WORDS+1); addresses never wrap past 2**AW.
// STRUCTURE
//  fb_pkg: fb_arb_state_t enum {IDLE,CLEAR,BURST}, FB_AW/FB_DW constants, word-address
//   helper function fb_word_addr(x,y) shared with trail writers.
//  Sub-module rr_arbiter #(N) (req, ptr -> one-hot pick, valid); rest is FSM + counters.
// TESTING
//  Single burst: req0 4 words A..A+3, last on 4th -> gnt0 next cycle, 4 fb_we pulses
//   addr A..A+3 each 1 cycle after ack, gnt0 low after.
//  Contention: req0 & req1 held, 2-word bursts -> grants alternate 0,1,0,1; rr_ptr wraps.
//  Stall: req0 drops 3 cycles mid-burst -> fb_we=0 those cycles, gnt0 held, data intact.
//  Timeout: MAX_BURST=4, req0 sends 6 words no last -> release after 4th, gnt1 next if req1.
//  Clear: CLEAR_WORDS=8, CLEAR_BASE=16, clear_start during burst -> burst finishes, then
//   8 writes addr 16..23 data 0, clear_busy high from pulse to last write.
//  Reset mid-clear at word 3 -> fb_we low next cycle, clear_busy=0, state IDLE.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the frame-buffer write path.
//   fb_arb_state_t : arbiter FSM state encoding
//   FB_AW / FB_DW  : default frame-buffer word address / data widths
//   fb_word_addr   : (x, y) pixel coordinate -> linear word address, used by
//                    the trail writers so they agree with the clear engine
package fb_write_arbiter_pkg;

  localparam int FB_AW    = 20;
  localparam int FB_DW    = 16;
  localparam int FB_H_RES = 640;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BURST = 2'd2
  } fb_arb_state_t;

  // Row-major layout, one word per pixel.
  function automatic logic [FB_AW-1:0] fb_word_addr(input logic [9:0] x, input logic [9:0] y);
    return (FB_AW'(y) * FB_AW'(FB_H_RES)) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle between the burst writers, the arbiter and the OCM write port.
//   req/last/wr_addr/wr_data : per-requester word offer (packed, index i at [i*W+:W])
//   gnt/ack                  : per-requester grant and word-accepted strobe
//   fb_we/fb_addr/fb_data    : OCM write port
// master : requester side (drives the offer, observes grant and OCM port)
// slave  : arbiter side
interface fb_write_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 20,
  parameter int DW    = 16
) ();

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*AW-1:0] wr_addr;
  logic [N_REQ*DW-1:0] wr_data;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic                fb_we;
  logic [AW-1:0]       fb_addr;
  logic [DW-1:0]       fb_data;

  modport master (
    output req, last, wr_addr, wr_data,
    input  gnt, ack, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  req, last, wr_addr, wr_data,
    output gnt, ack, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping N-1 -> 0.
//   req   in  N   request vector
//   ptr   in  PW  highest-priority index (must be < N)
//   pick  out N   one-hot chosen requester (zero when no request)
//   valid out 1   any request present
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_hi;
  logic [N-1:0] pick_lo;

  // Requests at or above ptr win first; otherwise wrap to the lowest index.
  assign mask    = ~((N'(1) << ptr) - N'(1));
  assign req_hi  = req & mask;
  // x & -x isolates the lowest set bit.
  assign pick_hi = req_hi & (~req_hi + N'(1));
  assign pick_lo = req & (~req + N'(1));
  assign pick    = (|req_hi) ? pick_hi : pick_lo;
  assign valid   = |req;

endmodule

// File: rtl/fb_write_arbiter.sv
// Sole owner of the frame-buffer write port. Grants it round-robin to N_REQ
// burst writers and to an internal clear engine that wipes the play area.
//   Clk         in  system clock
//   Reset       in  synchronous, active-high
//   clear_start in  1-cycle pulse requesting a play-area wipe
//   clear_busy  out high from clear accept until the last clear word is written
//   bus         slave side of fb_write_arbiter_if (requests, grants, OCM port)
// All OCM outputs and gnt are registered; ack = gnt & req is combinational.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int            AW          = FB_AW,
  parameter int            DW          = FB_DW,
  parameter int            N_REQ       = 2,
  parameter int            CLEAR_BASE  = 0,
  parameter int            CLEAR_WORDS = 307200,
  parameter logic [DW-1:0] CLEAR_VALUE = '0,
  parameter int            MAX_BURST   = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_start,
  output logic              clear_busy,
  fb_write_arbiter_if.slave bus
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CCW = $clog2(CLEAR_WORDS + 1);
  localparam int BCW = $clog2(MAX_BURST + 1);

  // The clear window must fit in the address space so the address never wraps.
  if (CLEAR_WORDS < 1 ||
      (longint'(CLEAR_BASE) + longint'(CLEAR_WORDS)) > (longint'(1) << AW)) begin : g_bad_clear
    $error("fb_write_arbiter: clear window does not fit in 2**AW words");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("fb_write_arbiter: MAX_BURST must be at least 1");
  end

  fb_arb_state_t    state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [PW-1:0]    rr_ptr_reg;
  logic [BCW-1:0]   burst_cnt_reg;
  logic [CCW-1:0]   clear_cnt_reg;
  logic [AW-1:0]    clear_addr_reg;
  logic             clear_pend_reg;
  logic             clear_busy_reg;
  logic             fb_we_reg;
  logic [AW-1:0]    fb_addr_reg;
  logic [DW-1:0]    fb_data_reg;

  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    next_ptr;
  logic             ack_any;
  logic             sel_last;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_ack
    assign ack[gi] = gnt_reg[gi] & bus.req[gi];
  end

  // gnt_reg is one-hot or zero, so an OR of the gated slices is the mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_reg[i]) begin
        sel_addr = sel_addr | bus.wr_addr[i*AW +: AW];
        sel_data = sel_data | bus.wr_data[i*DW +: DW];
        sel_idx  = PW'(i);
      end
    end
  end

  assign ack_any  = |ack;
  assign sel_last = |(ack & bus.last);
  assign next_ptr = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (bus.req),
    .ptr   (rr_ptr_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      rr_ptr_reg     <= '0;
      burst_cnt_reg  <= '0;
      clear_cnt_reg  <= '0;
      clear_addr_reg <= '0;
      clear_pend_reg <= 1'b0;
      clear_busy_reg <= 1'b0;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          fb_we_reg <= 1'b0;
          // A wipe always beats waiting requesters.
          if (clear_pend_reg || clear_start) begin
            state_reg      <= CLEAR;
            clear_pend_reg <= 1'b0;
            clear_busy_reg <= 1'b1;
            clear_cnt_reg  <= '0;
            clear_addr_reg <= AW'(CLEAR_BASE);
          end else if (pick_valid) begin
            state_reg     <= BURST;
            gnt_reg       <= pick;
            burst_cnt_reg <= '0;
          end
        end

        CLEAR: begin
          // clear_start is ignored here: a running wipe is never restarted.
          fb_we_reg      <= 1'b1;
          fb_addr_reg    <= clear_addr_reg;
          fb_data_reg    <= CLEAR_VALUE;
          clear_addr_reg <= clear_addr_reg + 1'b1;
          clear_cnt_reg  <= clear_cnt_reg + 1'b1;
          if (clear_cnt_reg == CCW'(CLEAR_WORDS - 1)) begin
            // busy falls on the same edge the last word's fb_we rises.
            state_reg      <= IDLE;
            clear_busy_reg <= 1'b0;
          end
        end

        BURST: begin
          if (clear_start) begin
            clear_pend_reg <= 1'b1;
            clear_busy_reg <= 1'b1;
          end
          if (ack_any) begin
            fb_we_reg     <= 1'b1;
            fb_addr_reg   <= sel_addr;
            fb_data_reg   <= sel_data;
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
            // The releasing word (last or MAX_BURST-th) is still written.
            if (sel_last || burst_cnt_reg == BCW'(MAX_BURST - 1)) begin
              state_reg  <= IDLE;
              gnt_reg    <= '0;
              rr_ptr_reg <= next_ptr;
            end
          end else begin
            // Granted requester stalled: hold the grant, write nothing.
            fb_we_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          fb_we_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.ack     = ack;
  assign bus.fb_we   = fb_we_reg;
  assign bus.fb_addr = fb_addr_reg;
  assign bus.fb_data = fb_data_reg;
  assign clear_busy  = clear_busy_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: single burst, contention, stall,
// timeout, clear behind a burst, and reset in the middle of a clear.
module tb_fb_write_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int CB    = 16;
  localparam int CW    = 8;
  localparam int MB    = 4;

  logic Clk = 1'b0;
  logic Reset;
  logic clear_start;
  logic clear_busy;

  int n_checks = 0;
  int n_fail   = 0;

  fb_write_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  fb_write_arbiter #(
    .AW(AW), .DW(DW), .N_REQ(N_REQ),
    .CLEAR_BASE(CB), .CLEAR_WORDS(CW), .CLEAR_VALUE(16'h0000), .MAX_BURST(MB)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .bus         (bus)
  );

  always #10 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int r);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int r, input logic rq, input logic lst,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[r]              = rq;
    bus.last[r]             = lst;
    bus.wr_addr[r*AW +: AW] = a;
    bus.wr_data[r*DW +: DW] = d;
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check_eq({tag, ".we"},   32'(bus.fb_we),   32'd1);
    check_eq({tag, ".addr"}, 32'(bus.fb_addr), 32'(a));
    check_eq({tag, ".data"}, 32'(bus.fb_data), 32'(d));
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    clear_start = 1'b0;
    bus.req     = '0;
    bus.last    = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  // Requester r is granted from IDLE, then presents n words from base without
  // stalling; the grant must drop right after the final (last or timeout) word.
  task automatic run_burst(input string tag, input int r, input logic [AW-1:0] base,
                           input int n, input logic with_last);
    logic [AW-1:0] a;
    drive(r, 1'b1, with_last && (n == 1), base, dat(base));
    step();
    check_eq({tag, ".gnt"},     32'(bus.gnt),   32'(onehot(r)));
    check_eq({tag, ".ack"},     32'(bus.ack),   32'(onehot(r)));
    check_eq({tag, ".idle_we"}, 32'(bus.fb_we), 32'd0);
    for (int w = 0; w < n; w++) begin
      a = base + AW'(w);
      drive(r, 1'b1, with_last && (w == n - 1), a, dat(a));
      step();
      check_write($sformatf("%s.w%0d", tag, w), a, dat(a));
      check_eq($sformatf("%s.gnt_w%0d", tag, w), 32'(bus.gnt),
               (w == n - 1) ? 32'd0 : 32'(onehot(r)));
    end
    $display("burst %s: requester %0d, %0d words from 0x%0h", tag, r, n, base);
  endtask

  initial begin
    logic [AW-1:0] a;

    Reset       = 1'b1;
    clear_start = 1'b0;
    bus.req     = '0;
    bus.last    = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset state
    step();
    step();
    check_eq("rst.gnt",        32'(bus.gnt),     32'd0);
    check_eq("rst.ack",        32'(bus.ack),     32'd0);
    check_eq("rst.fb_we",      32'(bus.fb_we),   32'd0);
    check_eq("rst.fb_addr",    32'(bus.fb_addr), 32'd0);
    check_eq("rst.fb_data",    32'(bus.fb_data), 32'd0);
    check_eq("rst.clear_busy", 32'(clear_busy),  32'd0);
    Reset = 1'b0;
    step();
    check_eq("idle.gnt", 32'(bus.gnt), 32'd0);
    $display("reset: outputs idle");

    // Single burst of 4 words ending with last
    run_burst("single", 0, 20'h000A0, 4, 1'b1);
    drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
    step();
    check_eq("single.after_we",  32'(bus.fb_we), 32'd0);
    check_eq("single.after_gnt", 32'(bus.gnt),   32'd0);

    // Contention: both requesters hold req, 2-word bursts alternate 0,1,0,1
    do_reset();
    drive(0, 1'b1, 1'b0, 20'h01000, dat(20'h01000));
    drive(1, 1'b1, 1'b0, 20'h02000, dat(20'h02000));
    run_burst("cont0a", 0, 20'h01000, 2, 1'b1);
    run_burst("cont1a", 1, 20'h02000, 2, 1'b1);
    run_burst("cont0b", 0, 20'h01010, 2, 1'b1);
    run_burst("cont1b", 1, 20'h02010, 2, 1'b1);
    bus.req = '0;
    step();

    // Stall: requester 0 drops req for 3 cycles mid-burst
    do_reset();
    drive(0, 1'b1, 1'b0, 20'h00300, dat(20'h00300));
    step();
    check_eq("stall.gnt", 32'(bus.gnt), 32'd1);
    for (int w = 0; w < 2; w++) begin
      a = 20'h00300 + AW'(w);
      drive(0, 1'b1, 1'b0, a, dat(a));
      step();
      check_write($sformatf("stall.w%0d", w), a, dat(a));
    end
    for (int s = 0; s < 3; s++) begin
      drive(0, 1'b0, 1'b0, 20'hFFFFF, 16'hDEAD);
      step();
      check_eq($sformatf("stall.s%0d.we", s),  32'(bus.fb_we), 32'd0);
      check_eq($sformatf("stall.s%0d.gnt", s), 32'(bus.gnt),   32'd1);
      check_eq($sformatf("stall.s%0d.ack", s), 32'(bus.ack),   32'd0);
    end
    for (int w = 2; w < 4; w++) begin
      a = 20'h00300 + AW'(w);
      drive(0, 1'b1, (w == 3), a, dat(a));
      step();
      check_write($sformatf("stall.w%0d", w), a, dat(a));
    end
    check_eq("stall.release", 32'(bus.gnt), 32'd0);
    drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
    $display("burst stall: requester 0, 4 words with 3-cycle stall");

    // Timeout: 6 words without last, MAX_BURST=4 forces release, req1 next
    do_reset();
    drive(1, 1'b1, 1'b1, 20'h04000, dat(20'h04000));
    run_burst("tmo0a", 0, 20'h03000, 4, 1'b0);
    drive(0, 1'b1, 1'b0, 20'h03004, dat(20'h03004));
    run_burst("tmo1", 1, 20'h04000, 1, 1'b1);
    drive(1, 1'b0, 1'b0, 20'h0, 16'h0);
    run_burst("tmo0b", 0, 20'h03004, 2, 1'b1);
    drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
    step();

    // Clear requested during a burst: burst finishes, then 8 clear words
    do_reset();
    drive(1, 1'b1, 1'b1, 20'h05100, dat(20'h05100));
    drive(0, 1'b1, 1'b0, 20'h05000, dat(20'h05000));
    step();
    check_eq("clr.gnt", 32'(bus.gnt), 32'd1);
    step();
    check_write("clr.w0", 20'h05000, dat(20'h05000));
    drive(0, 1'b1, 1'b0, 20'h05001, dat(20'h05001));
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check_write("clr.w1", 20'h05001, dat(20'h05001));
    check_eq("clr.busy_pend", 32'(clear_busy), 32'd1);
    check_eq("clr.gnt_w1",    32'(bus.gnt),    32'd1);
    drive(0, 1'b1, 1'b1, 20'h05002, dat(20'h05002));
    step();
    check_write("clr.w2", 20'h05002, dat(20'h05002));
    check_eq("clr.gnt_w2",  32'(bus.gnt),    32'd0);
    check_eq("clr.busy_w2", 32'(clear_busy), 32'd1);
    drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
    step();
    check_eq("clr.enter_we",   32'(bus.fb_we),  32'd0);
    check_eq("clr.enter_gnt",  32'(bus.gnt),    32'd0);
    check_eq("clr.enter_busy", 32'(clear_busy), 32'd1);
    for (int k = 0; k < CW; k++) begin
      if (k == 2) clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      check_write($sformatf("clr.c%0d", k), AW'(CB + k), 16'h0000);
      check_eq($sformatf("clr.c%0d.busy", k), 32'(clear_busy), (k == CW - 1) ? 32'd0 : 32'd1);
      check_eq($sformatf("clr.c%0d.gnt", k),  32'(bus.gnt),    32'd0);
    end
    step();
    check_eq("clr.done_we",   32'(bus.fb_we),  32'd0);
    check_eq("clr.done_gnt",  32'(bus.gnt),    32'd2);
    check_eq("clr.done_busy", 32'(clear_busy), 32'd0);
    $display("clear: 8 words at 0x%0h after burst, restart pulse ignored", CB);

    // clear_start and req together in IDLE, then reset at clear word 3
    do_reset();
    drive(0, 1'b1, 1'b0, 20'h00700, dat(20'h00700));
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check_eq("rc.gnt",  32'(bus.gnt),    32'd0);
    check_eq("rc.busy", 32'(clear_busy), 32'd1);
    check_eq("rc.we",   32'(bus.fb_we),  32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_write($sformatf("rc.c%0d", k), AW'(CB + k), 16'h0000);
      check_eq($sformatf("rc.c%0d.gnt", k), 32'(bus.gnt), 32'd0);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("rc.rst_we",   32'(bus.fb_we),  32'd0);
    check_eq("rc.rst_busy", 32'(clear_busy), 32'd0);
    check_eq("rc.rst_gnt",  32'(bus.gnt),    32'd0);
    step();
    check_eq("rc.post_gnt",  32'(bus.gnt),    32'd1);
    check_eq("rc.post_we",   32'(bus.fb_we),  32'd0);
    check_eq("rc.post_busy", 32'(clear_busy), 32'd0);
    drive(0, 1'b1, 1'b1, 20'h00700, dat(20'h00700));
    step();
    check_write("rc.w0", 20'h00700, dat(20'h00700));
    check_eq("rc.w0_gnt", 32'(bus.gnt), 32'd0);
    drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
    $display("reset mid-clear: aborted at word 3, pending clear discarded");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
